sorter_group_feeder: RTL and testbench
======================================

Name: sorter_group_feeder

Overview:
- Upstream stage for the 4-entry array sorter.
- Accepts a byte stream on a valid/ready handshake and buffers it in a small FIFO.
- Releases data to the sorter only as complete, back-to-back groups of GROUP bytes, each marked with first/last flags.
- Inserts a programmable idle gap between groups so the sorter's index wrap and compare-swap settle before the next group arrives.

Parameters:
- DATA_W, 8, data byte width
- DEPTH, 8, FIFO entries (power of two, >= GROUP)
- GROUP, 4, bytes per released group
- GAP_CYCLES, 1, idle cycles after each group (0 allowed)

Ports:
- clk  input  1  clock
- rst  input  1  reset, asynchronous, active-high
- flush  input  1  synchronous FIFO/state clear
- in_valid  input  1  upstream byte valid
- in_ready  output  1  feeder can accept a byte
- in_data  input  DATA_W  upstream byte
- out_valid  output  1  byte presented to sorter
- out_ready  input  1  sorter accepts byte
- out_data  output  DATA_W  byte to sorter
- out_first  output  1  first beat of group
- out_last  output  1  last beat of group
- level  output  log2(DEPTH)+1  current FIFO occupancy
- group_cnt  output  8  completed groups, wraps 255->0

Behaviour:
- Reset (async, rst=1):
  - wr/rd pointers = 0, level = 0, state = IDLE, beat counter = 0, gap counter = 0, group_cnt = 0.
  - out_valid/out_first/out_last = 0, out_data = 0.
  - in_ready = 1 (unless flush is high). Memory contents are not reset.
- in_ready = (level < DEPTH) && !flush. No write bypass at full: a read in the same cycle does not free a slot for a write until the next cycle.
- Write: occurs on in_valid && in_ready. Read: occurs on out_valid && out_ready. Both may occur in one cycle; level is unchanged in that case.
- FSM:
  - IDLE: if level >= GROUP, go to BURST next edge. The decision uses registered level, so the 4th accepted byte at edge E gives out_valid high after edge E+1.
  - BURST:
    - out_valid = 1 and out_data = FIFO head.
    - out_first = (beat == 0), out_last = (beat == GROUP-1).
    - beat increments on each handshake. out_ready low stalls with all outputs held stable.
    - On the last-beat handshake: group_cnt += 1, beat = 0, go to GAP (or IDLE if GAP_CYCLES = 0).
  - GAP: out_valid = 0. Stays for exactly GAP_CYCLES cycles, then IDLE. Writes continue during GAP.
- Outside BURST, out_valid/out_first/out_last = 0 and out_data = 0.
- A group is never split: BURST is entered only with >= GROUP bytes stored, so level never underflows during a burst.
- flush (sync, highest priority below rst):
  - Clears pointers, level, beat and gap counters. state = IDLE, effective from the next edge.
  - An in-flight burst is abandoned with no out_last.
  - in_valid during the flush cycle is ignored (in_ready = 0).
  - group_cnt is not cleared.
- Reset mid-burst: outputs drop immediately (async). No partial group is resumed.
- Pointers wrap modulo DEPTH. group_cnt wraps 255->0 silently.

Test Plan:
- Reset, then 4 bytes 0x11,0x22,0x33,0x44 with out_ready = 1 -> out_valid rises 1 cycle after the 4th accept. Data 0x11..0x44 on consecutive cycles, out_first on 0x11, out_last on 0x44. group_cnt = 1, then 1 gap cycle with out_valid = 0.
- Feed 3 bytes only -> out_valid stays 0 indefinitely, level = 3. A 4th byte triggers the burst.
- Fill 8 bytes with out_ready = 0 -> in_ready = 0 at level = 8, a 9th byte is not accepted. Toggle out_ready 1/0 -> outputs hold during stalls. Two groups emerge in order, group_cnt = 2, with a gap between them.
- Pulse flush on the 2nd beat of a burst -> out_valid = 0 next cycle with no out_last, level = 0, group_cnt unchanged. The next 4 bytes form a clean group.
- Assert rst mid-burst -> out_valid = 0 immediately, level = 0, group_cnt = 0. Run 260 groups -> group_cnt wraps to 4. Run with GAP_CYCLES = 0 -> back-to-back groups with 1 IDLE cycle between them.

Source files
------------

// File: rtl/sorter_group_feeder.sv
// sorter_group_feeder
//   Upstream stage for the 4-entry array sorter. Buffers a byte stream in a
//   small FIFO and releases it only as complete back-to-back groups of GROUP
//   bytes, tagged with first/last. After each group it waits GAP_CYCLES idle
//   cycles so the sorter can settle before the next group arrives.
//
// Ports
//   clk        clock
//   rst        asynchronous active-high reset
//   flush      synchronous clear of FIFO, beat and gap state (group_cnt kept)
//   in_valid   upstream byte valid
//   in_ready   feeder can accept a byte (combinational: level < DEPTH && !flush)
//   in_data    upstream byte
//   out_valid  byte presented to sorter
//   out_ready  sorter accepts byte
//   out_data   byte to sorter (0 outside a burst)
//   out_first  first beat of group
//   out_last   last beat of group
//   level      current FIFO occupancy
//   group_cnt  completed groups, wraps 255->0
module sorter_group_feeder #(
    parameter int unsigned DATA_W     = 8,
    parameter int unsigned DEPTH      = 8,
    parameter int unsigned GROUP      = 4,
    parameter int unsigned GAP_CYCLES = 1
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      flush,
    input  logic                      in_valid,
    output logic                      in_ready,
    input  logic [DATA_W-1:0]         in_data,
    output logic                      out_valid,
    input  logic                      out_ready,
    output logic [DATA_W-1:0]         out_data,
    output logic                      out_first,
    output logic                      out_last,
    output logic [$clog2(DEPTH):0]    level,
    output logic [7:0]                group_cnt
);

    localparam int unsigned PTR_W  = $clog2(DEPTH);
    localparam int unsigned LVL_W  = PTR_W + 1;
    localparam int unsigned BEAT_W = $clog2(GROUP + 1);
    localparam int unsigned GAP_W  = $clog2(GAP_CYCLES + 2);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_BURST = 2'd1,
        S_GAP   = 2'd2
    } state_e;

    state_e              state_q, state_d;
    logic [PTR_W-1:0]    wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]    rd_ptr_q, rd_ptr_d;
    logic [LVL_W-1:0]    level_q, level_d;
    logic [BEAT_W-1:0]   beat_q, beat_d;
    logic [GAP_W-1:0]    gap_q, gap_d;
    logic [7:0]          grp_q, grp_d;
    logic                out_valid_q, out_valid_d;
    logic                out_first_q, out_first_d;
    logic                out_last_q, out_last_d;
    logic [DATA_W-1:0]   out_data_q, out_data_d;
    logic [DATA_W-1:0]   mem_q [DEPTH];
    logic                wr_en;
    logic                rd_en;

    // No write bypass at full: a same-cycle read frees the slot only next cycle.
    assign in_ready = (level_q < LVL_W'(DEPTH)) && !flush;
    assign wr_en    = in_valid && in_ready;
    assign rd_en    = out_valid_q && out_ready;

    assign out_valid = out_valid_q;
    assign out_first = out_first_q;
    assign out_last  = out_last_q;
    assign out_data  = out_data_q;
    assign level     = level_q;
    assign group_cnt = grp_q;

    // FIFO storage, intentionally not reset.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem_q[wr_ptr_q] <= in_data;
        end
    end

    // State and datapath registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= S_IDLE;
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            level_q     <= '0;
            beat_q      <= '0;
            gap_q       <= '0;
            grp_q       <= '0;
            out_valid_q <= 1'b0;
            out_first_q <= 1'b0;
            out_last_q  <= 1'b0;
            out_data_q  <= '0;
        end else begin
            state_q     <= state_d;
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            level_q     <= level_d;
            beat_q      <= beat_d;
            gap_q       <= gap_d;
            grp_q       <= grp_d;
            out_valid_q <= out_valid_d;
            out_first_q <= out_first_d;
            out_last_q  <= out_last_d;
            out_data_q  <= out_data_d;
        end
    end

    // Next-state, FIFO bookkeeping and next output values.
    always_comb begin
        state_d     = state_q;
        wr_ptr_d    = wr_ptr_q;
        rd_ptr_d    = rd_ptr_q;
        level_d     = level_q;
        beat_d      = beat_q;
        gap_d       = gap_q;
        grp_d       = grp_q;
        out_valid_d = 1'b0;
        out_first_d = 1'b0;
        out_last_d  = 1'b0;
        out_data_d  = '0;

        if (flush) begin
            // Abandons any in-flight burst; group_cnt survives.
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            level_d  = '0;
            beat_d   = '0;
            gap_d    = '0;
            state_d  = S_IDLE;
        end else begin
            if (wr_en) begin
                wr_ptr_d = wr_ptr_q + PTR_W'(1);
            end
            if (rd_en) begin
                rd_ptr_d = rd_ptr_q + PTR_W'(1);
            end
            case ({wr_en, rd_en})
                2'b10:   level_d = level_q + LVL_W'(1);
                2'b01:   level_d = level_q - LVL_W'(1);
                default: level_d = level_q;
            endcase

            case (state_q)
                S_IDLE: begin
                    // Only a full group may start a burst, so it never underflows.
                    if (level_q >= LVL_W'(GROUP)) begin
                        state_d = S_BURST;
                    end
                end
                S_BURST: begin
                    if (rd_en) begin
                        if (beat_q == BEAT_W'(GROUP - 1)) begin
                            beat_d = '0;
                            grp_d  = grp_q + 8'd1;
                            gap_d  = '0;
                            if (GAP_CYCLES == 0) begin
                                state_d = S_IDLE;
                            end else begin
                                state_d = S_GAP;
                            end
                        end else begin
                            beat_d = beat_q + BEAT_W'(1);
                        end
                    end
                end
                S_GAP: begin
                    if (gap_q == GAP_W'(GAP_CYCLES - 1)) begin
                        state_d = S_IDLE;
                    end else begin
                        gap_d = gap_q + GAP_W'(1);
                    end
                end
                default: begin
                    state_d = S_IDLE;
                end
            endcase
        end

        // Outputs are registered: present the head the FIFO will have next cycle.
        if (state_d == S_BURST) begin
            out_valid_d = 1'b1;
            out_data_d  = mem_q[rd_ptr_d];
            out_first_d = (beat_d == '0);
            out_last_d  = (beat_d == BEAT_W'(GROUP - 1));
        end
    end

endmodule

// File: tb/tb_sorter_group_feeder.sv
module tb_sorter_group_feeder;

    logic       clk;
    logic       rst;

    // Main instance (GAP_CYCLES = 1)
    logic       flush;
    logic       in_valid;
    logic       in_ready;
    logic [7:0] in_data;
    logic       out_valid;
    logic       out_ready;
    logic [7:0] out_data;
    logic       out_first;
    logic       out_last;
    logic [3:0] level;
    logic [7:0] group_cnt;

    // Second instance (GAP_CYCLES = 0)
    logic       flush0;
    logic       in_valid0;
    logic       in_ready0;
    logic [7:0] in_data0;
    logic       out_valid0;
    logic       out_ready0;
    logic [7:0] out_data0;
    logic       out_first0;
    logic       out_last0;
    logic [3:0] level0;
    logic [7:0] group_cnt0;

    sorter_group_feeder #(.DATA_W(8), .DEPTH(8), .GROUP(4), .GAP_CYCLES(1)) dut (
        .clk       (clk),
        .rst       (rst),
        .flush     (flush),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_first (out_first),
        .out_last  (out_last),
        .level     (level),
        .group_cnt (group_cnt)
    );

    sorter_group_feeder #(.DATA_W(8), .DEPTH(8), .GROUP(4), .GAP_CYCLES(0)) dut0 (
        .clk       (clk),
        .rst       (rst),
        .flush     (flush0),
        .in_valid  (in_valid0),
        .in_ready  (in_ready0),
        .in_data   (in_data0),
        .out_valid (out_valid0),
        .out_ready (out_ready0),
        .out_data  (out_data0),
        .out_first (out_first0),
        .out_last  (out_last0),
        .level     (level0),
        .group_cnt (group_cnt0)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int         checks = 0;
    int         errors = 0;

    // Scoreboard: bytes accepted but not yet delivered, in order.
    logic [7:0] sb [$];
    int         beat = 0;
    logic [7:0] grp = 8'd0;
    int         age = 100;
    logic       last_acc = 1'b0;
    logic       prev_valid = 1'b0;
    logic       prev_hs = 1'b0;
    logic [7:0] prev_data = 8'd0;
    logic       prev_first = 1'b0;
    logic       prev_last = 1'b0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One cycle on the main instance: drive, sample before the edge, update the model.
    task automatic tick(input logic v, input logic [7:0] d, input logic rdy, input logic fl);
        logic [7:0] exp_b;
        logic       acc;
        logic       hs;
        @(negedge clk);
        in_valid  = v;
        in_data   = d;
        out_ready = rdy;
        flush     = fl;
        #1;
        if (age < 100) age++;
        chk("level", 32'(level), 32'(sb.size()));
        chk("group_cnt", 32'(group_cnt), 32'(grp));
        chk("in_ready", 32'(in_ready), 32'((sb.size() < 8) && !fl));
        if (age == 1 || age == 2) chk("gap_idle", 32'(out_valid), 32'd0);
        if (prev_valid && !prev_hs) begin
            chk("stall_valid", 32'(out_valid), 32'd1);
            chk("stall_data", 32'(out_data), 32'(prev_data));
            chk("stall_flags", 32'({out_first, out_last}), 32'({prev_first, prev_last}));
        end
        if (!out_valid) chk("idle_zero", 32'({out_first, out_last, out_data}), 32'd0);

        acc        = v && in_ready;
        hs         = out_valid && rdy;
        last_acc   = acc;
        prev_valid = out_valid && !fl;
        prev_hs    = hs;
        prev_data  = out_data;
        prev_first = out_first;
        prev_last  = out_last;

        if (fl) begin
            sb.delete();
            beat = 0;
            age  = 100;
        end else begin
            if (hs) begin
                if (sb.size() == 0) begin
                    chk("spurious_valid", 32'(out_valid), 32'd0);
                end else begin
                    exp_b = sb.pop_front();
                    chk("out_data", 32'(out_data), 32'(exp_b));
                    chk("out_first", 32'(out_first), 32'(beat == 0));
                    chk("out_last", 32'(out_last), 32'(beat == 3));
                    if (beat == 3) begin
                        beat = 0;
                        grp  = grp + 8'd1;
                        age  = 0;
                    end else begin
                        beat++;
                    end
                end
            end
            if (acc) sb.push_back(d);
        end
    endtask

    task automatic drain();
        int n;
        n = 0;
        do begin
            tick(1'b0, 8'h00, 1'b1, 1'b0);
            n++;
        end while ((sb.size() != 0 || out_valid) && n < 100);
        chk("drain_timeout", 32'(sb.size()), 32'd0);
    endtask

    initial begin
        int         accepted;
        int         n;
        logic [7:0] exp_d;
        logic       exp_v;

        rst        = 1'b1;
        flush      = 1'b0;
        in_valid   = 1'b0;
        in_data    = 8'h00;
        out_ready  = 1'b0;
        flush0     = 1'b0;
        in_valid0  = 1'b0;
        in_data0   = 8'h00;
        out_ready0 = 1'b0;
        #1;
        chk("rst_out", 32'({out_valid, out_first, out_last, out_data}), 32'd0);
        chk("rst_level", 32'(level), 32'd0);
        chk("rst_group", 32'(group_cnt), 32'd0);
        chk("rst_in_ready", 32'(in_ready), 32'd1);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;

        // Basic group: latency, ordering, flags, gap.
        tick(1'b1, 8'h11, 1'b1, 1'b0);
        tick(1'b1, 8'h22, 1'b1, 1'b0);
        tick(1'b1, 8'h33, 1'b1, 1'b0);
        tick(1'b1, 8'h44, 1'b1, 1'b0);
        tick(1'b0, 8'h00, 1'b1, 1'b0);
        chk("t1_latency_low", 32'(out_valid), 32'd0);
        tick(1'b0, 8'h00, 1'b1, 1'b0);
        chk("t1_valid_rise", 32'({out_valid, out_first, out_data}), 32'({1'b1, 1'b1, 8'h11}));
        tick(1'b0, 8'h00, 1'b1, 1'b0);
        tick(1'b0, 8'h00, 1'b1, 1'b0);
        tick(1'b0, 8'h00, 1'b1, 1'b0);
        chk("t1_last", 32'({out_last, out_data}), 32'({1'b1, 8'h44}));
        tick(1'b0, 8'h00, 1'b1, 1'b0);
        chk("t1_gap", 32'(out_valid), 32'd0);
        chk("t1_group", 32'(group_cnt), 32'd1);
        drain();

        // Partial group is held until the 4th byte.
        tick(1'b1, 8'hA1, 1'b1, 1'b0);
        tick(1'b1, 8'hA2, 1'b1, 1'b0);
        tick(1'b1, 8'hA3, 1'b1, 1'b0);
        for (int i = 0; i < 6; i++) begin
            tick(1'b0, 8'h00, 1'b1, 1'b0);
            chk("partial_hold", 32'(out_valid), 32'd0);
        end
        chk("partial_level", 32'(level), 32'd3);
        tick(1'b1, 8'hA4, 1'b1, 1'b0);
        drain();
        chk("t2_group", 32'(group_cnt), 32'd2);

        // Fill to full with sink stalled; 9th byte refused; toggled drain.
        for (int i = 0; i < 9; i++) begin
            tick(1'b1, 8'(8'hB0 + i), 1'b0, 1'b0);
        end
        chk("full_level", 32'(level), 32'd8);
        chk("full_in_ready", 32'(in_ready), 32'd0);
        for (int i = 0; i < 30; i++) begin
            tick(1'b0, 8'h00, 1'(i % 2 == 0), 1'b0);
        end
        drain();
        chk("t3_group", 32'(group_cnt), 32'd4);

        // Flush on the second beat of a burst.
        tick(1'b1, 8'hC1, 1'b1, 1'b0);
        tick(1'b1, 8'hC2, 1'b1, 1'b0);
        tick(1'b1, 8'hC3, 1'b1, 1'b0);
        tick(1'b1, 8'hC4, 1'b1, 1'b0);
        tick(1'b0, 8'h00, 1'b1, 1'b0);
        tick(1'b0, 8'h00, 1'b1, 1'b0);
        chk("t4_first_beat", 32'({out_valid, out_first}), 32'({1'b1, 1'b1}));
        tick(1'b1, 8'hEE, 1'b1, 1'b1);
        chk("t4_second_beat", 32'({out_valid, out_data}), 32'({1'b1, 8'hC2}));
        tick(1'b0, 8'h00, 1'b1, 1'b0);
        chk("t4_flush_drop", 32'({out_valid, out_last}), 32'd0);
        chk("t4_flush_level", 32'(level), 32'd0);
        chk("t4_flush_group", 32'(group_cnt), 32'd4);
        tick(1'b1, 8'hD1, 1'b1, 1'b0);
        tick(1'b1, 8'hD2, 1'b1, 1'b0);
        tick(1'b1, 8'hD3, 1'b1, 1'b0);
        tick(1'b1, 8'hD4, 1'b1, 1'b0);
        drain();
        chk("t4_group", 32'(group_cnt), 32'd5);

        // Asynchronous reset mid-burst.
        tick(1'b1, 8'hE1, 1'b1, 1'b0);
        tick(1'b1, 8'hE2, 1'b1, 1'b0);
        tick(1'b1, 8'hE3, 1'b1, 1'b0);
        tick(1'b1, 8'hE4, 1'b1, 1'b0);
        tick(1'b0, 8'h00, 1'b1, 1'b0);
        tick(1'b0, 8'h00, 1'b1, 1'b0);
        chk("t5_in_burst", 32'(out_valid), 32'd1);
        @(negedge clk);
        #2;
        rst = 1'b1;
        #1;
        chk("t5_rst_valid", 32'({out_valid, out_first, out_last, out_data}), 32'd0);
        chk("t5_rst_level", 32'(level), 32'd0);
        chk("t5_rst_group", 32'(group_cnt), 32'd0);
        sb.delete();
        beat       = 0;
        grp        = 8'd0;
        age        = 100;
        prev_valid = 1'b0;
        @(negedge clk);
        rst = 1'b0;

        // 260 groups: group_cnt wraps to 4.
        accepted = 0;
        n = 0;
        while (accepted < 1040 && n < 8000) begin
            tick(1'b1, 8'($urandom_range(0, 255)), 1'($urandom_range(0, 3) != 0), 1'b0);
            if (last_acc) accepted++;
            n++;
        end
        chk("feed_timeout", 32'(accepted), 32'd1040);
        drain();
        chk("wrap", 32'(group_cnt), 32'd4);

        // GAP_CYCLES = 0: one idle cycle between back-to-back groups.
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            in_valid0  = 1'b1;
            in_data0   = 8'(i + 1);
            out_ready0 = 1'b0;
            #1;
            chk("g0_in_ready", 32'(in_ready0), 32'd1);
        end
        @(negedge clk);
        in_valid0 = 1'b0;
        #1;
        chk("g0_full_level", 32'(level0), 32'd8);
        chk("g0_full_ready", 32'(in_ready0), 32'd0);
        for (int c = 0; c < 10; c++) begin
            if (c != 0) @(negedge clk);
            out_ready0 = 1'b1;
            #1;
            exp_v = (c != 4) && (c != 9);
            exp_d = !exp_v ? 8'h00 : (c < 4) ? 8'(c + 1) : 8'(c);
            chk("g0_valid", 32'(out_valid0), 32'(exp_v));
            chk("g0_data", 32'(out_data0), 32'(exp_d));
            chk("g0_flags", 32'({out_first0, out_last0}),
                32'({(c == 0 || c == 5), (c == 3 || c == 8)}));
        end
        chk("g0_group", 32'(group_cnt0), 32'd2);
        chk("g0_level", 32'(level0), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
